// File: rtl/multicycle_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute over a
// handshaked memory, with a per-state wait timeout that aborts to a fresh fetch.
module multicycle_controller #(
   parameter int TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] Opcode,
   input  logic [5:0] Funct,
   input  logic       Zero,
   input  logic       mem_ready,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic       PCEn,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSrc,
   output logic [2:0] ALUControl,
   output logic [3:0] state_o,
   output logic       illegal,
   output logic       bus_error
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
      MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
      BRANCH = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   state_t     state, next;
   logic [7:0] wait_cnt;
   logic       mem_state, timeout;
   logic       funct_ok;
   logic [2:0] funct_alu;

   assign mem_state = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
   // mem_ready wins: a timeout only fires in a cycle where memory is still not ready
   assign timeout   = mem_state && !mem_ready && (wait_cnt == 8'(TIMEOUT));
   assign state_o   = state;

   always_comb begin
      funct_ok  = 1'b1;
      funct_alu = 3'b000;
      case (Funct)
         6'b100000: funct_alu = 3'b010;
         6'b100010: funct_alu = 3'b110;
         6'b100100: funct_alu = 3'b000;
         6'b100101: funct_alu = 3'b001;
         6'b101010: funct_alu = 3'b111;
         default:   funct_ok  = 1'b0;
      endcase
   end

   always_comb begin
      next = state;
      case (state)
         FETCH:  if (mem_ready) next = DECODE;
                 else if (timeout) next = FETCH;
         DECODE: case (Opcode)
                    OP_LW, OP_SW: next = MEMADR;
                    OP_RTYPE:     next = EXEC;
                    OP_BEQ:       next = BRANCH;
                    OP_ADDI:      next = ADDIEX;
                    OP_J:         next = JUMP;
                    default:      next = FETCH;
                 endcase
         MEMADR: next = (Opcode == OP_LW) ? MEMRD : MEMWR;
         MEMRD:  if (mem_ready) next = MEMWB;
                 else if (timeout) next = FETCH;
         MEMWR:  if (mem_ready || timeout) next = FETCH;
         EXEC:   next = funct_ok ? ALUWB : FETCH;
         ADDIEX: next = ADDIWB;
         default: next = FETCH;
      endcase
   end

   // Counter restarts on every state entry, including a timeout re-entry of FETCH
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= FETCH;
         wait_cnt <= 8'd0;
      end else begin
         state <= next;
         if (next != state || timeout)
            wait_cnt <= 8'd0;
         else if (mem_state && !mem_ready)
            wait_cnt <= wait_cnt + 8'd1;
      end
   end

   always_comb begin
      IorD = 1'b0;  MemRead = 1'b0;  MemWrite = 1'b0;  IRWrite = 1'b0;
      RegDst = 1'b0;  MemtoReg = 1'b0;  RegWrite = 1'b0;  ALUSrcA = 1'b0;
      PCEn = 1'b0;  ALUSrcB = 2'b00;  PCSrc = 2'b00;  ALUControl = 3'b000;
      illegal = 1'b0;  bus_error = 1'b0;
      case (state)
         FETCH: begin
            MemRead = 1'b1;  ALUSrcB = 2'b01;  ALUControl = 3'b010;
            IRWrite = mem_ready;  PCEn = mem_ready;  bus_error = timeout;
         end
         DECODE: begin
            ALUSrcB = 2'b11;  ALUControl = 3'b010;
            illegal = !(Opcode inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J});
         end
         MEMADR: begin ALUSrcA = 1'b1;  ALUSrcB = 2'b10;  ALUControl = 3'b010; end
         MEMRD:  begin MemRead = 1'b1;  IorD = 1'b1;  bus_error = timeout; end
         MEMWB:  begin RegWrite = 1'b1;  MemtoReg = 1'b1; end
         MEMWR:  begin MemWrite = !timeout;  IorD = 1'b1;  bus_error = timeout; end
         EXEC:   begin ALUSrcA = 1'b1;  ALUControl = funct_alu;  illegal = !funct_ok; end
         ALUWB:  begin RegWrite = 1'b1;  RegDst = 1'b1; end
         BRANCH: begin
            ALUSrcA = 1'b1;  ALUControl = 3'b110;  PCSrc = 2'b01;  PCEn = Zero;
         end
         ADDIEX: begin ALUSrcA = 1'b1;  ALUSrcB = 2'b10;  ALUControl = 3'b010; end
         ADDIWB: RegWrite = 1'b1;
         JUMP:   begin PCSrc = 2'b10;  PCEn = 1'b1; end
         default: ;
      endcase
      // reset parks the FSM in FETCH but must not let its strobes through
      if (!rst) begin
         MemRead = 1'b0;  MemWrite = 1'b0;  IRWrite = 1'b0;  PCEn = 1'b0;
         RegWrite = 1'b0;  illegal = 1'b0;  bus_error = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench: builds the expected per-cycle state/output trace of each
// instruction from its opcode and memory wait pattern, then replays it on the DUT.
module tb_multicycle_controller;
   localparam int TO = 4;
   localparam logic [5:0] RT = 6'h00, LW = 6'h23, SW = 6'h2b, BEQ = 6'h04,
                          ADDI = 6'h08, J = 6'h02;

   logic clk = 1'b0, rst = 1'b0;
   logic [5:0] Opcode = '0, Funct = '0;
   logic Zero = 1'b0, mem_ready = 1'b0;
   logic IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn;
   logic [1:0] ALUSrcB, PCSrc;
   logic [2:0] ALUControl;
   logic [3:0] state_o;
   logic illegal, bus_error;

   multicycle_controller #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
      .mem_ready(mem_ready), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
      .ALUSrcA(ALUSrcA), .PCEn(PCEn), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
      .ALUControl(ALUControl), .state_o(state_o), .illegal(illegal), .bus_error(bus_error)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic iord, mr, mw, irw, rd, m2r, rw, sa, pce;
      logic [1:0] sb, pcs;
      logic [2:0] ac;
      logic ill, be;
   } o_t;
   typedef struct { int st; bit rdy; bit to; } cyc_t;

   o_t obs;
   assign obs = {IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                 PCEn, ALUSrcB, PCSrc, ALUControl, illegal, bus_error};

   int total = 0, bad = 0;
   cyc_t q[$];

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit fn_ok(logic [5:0] fn);
      return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
   endfunction

   function automatic logic [2:0] fn_alu(logic [5:0] fn);
      case (fn)
         6'h20: return 3'b010;  6'h22: return 3'b110;  6'h25: return 3'b001;
         6'h2a: return 3'b111;  default: return 3'b000;
      endcase
   endfunction

   function automatic o_t exp_out(int st, bit rdy, bit to, logic [5:0] op, logic [5:0] fn, bit z);
      o_t o = '0;
      case (st)
         0:  begin o.mr = 1; o.sb = 2'b01; o.ac = 3'b010;
                   o.irw = rdy; o.pce = rdy; o.be = to; end
         1:  begin o.sb = 2'b11; o.ac = 3'b010;
                   o.ill = !(op inside {RT, LW, SW, BEQ, ADDI, J}); end
         2:  begin o.sa = 1; o.sb = 2'b10; o.ac = 3'b010; end
         3:  begin o.mr = 1; o.iord = 1; o.be = to; end
         4:  begin o.rw = 1; o.m2r = 1; end
         5:  begin o.mw = !to; o.iord = 1; o.be = to; end
         6:  begin o.sa = 1; o.ac = fn_alu(fn); o.ill = !fn_ok(fn); end
         7:  begin o.rw = 1; o.rd = 1; end
         8:  begin o.sa = 1; o.ac = 3'b110; o.pcs = 2'b01; o.pce = z; end
         9:  begin o.sa = 1; o.sb = 2'b10; o.ac = 3'b010; end
         10: o.rw = 1;
         11: begin o.pcs = 2'b10; o.pce = 1; end
         default: ;
      endcase
      return o;
   endfunction

   function automatic o_t rst_out();
      o_t o = '0;
      o.sb = 2'b01; o.ac = 3'b010;
      return o;
   endfunction

   // w not-ready cycles; more than TO of them means the phase times out
   task automatic mem_phase(int st, int w, output bit ab);
      ab = (w > TO);
      if (ab) for (int i = 0; i <= TO; i++) q.push_back('{st, 1'b0, i == TO});
      else begin
         for (int i = 0; i < w; i++) q.push_back('{st, 1'b0, 1'b0});
         q.push_back('{st, 1'b1, 1'b0});
      end
   endtask

   task automatic any(int st);
      q.push_back('{st, 1'($urandom % 2), 1'b0});
   endtask

   // Called just after a negedge; returns just after a negedge.
   task automatic run_instr(logic [5:0] op, logic [5:0] fn, bit z, int wf, int wm, int abort_at);
      bit ab;
      q.delete();
      mem_phase(0, wf, ab);
      if (!ab) begin
         any(1);
         case (op)
            LW:   begin any(2); mem_phase(3, wm, ab); if (!ab) any(4); end
            SW:   begin any(2); mem_phase(5, wm, ab); end
            RT:   begin any(6); if (fn_ok(fn)) any(7); end
            BEQ:  any(8);
            ADDI: begin any(9); any(10); end
            J:    any(11);
            default: ;
         endcase
      end
      for (int i = 0; i < q.size(); i++) begin
         Opcode = op; Funct = fn; Zero = z; mem_ready = q[i].rdy;
         #1;
         if (i == abort_at) begin
            rst = 1'b0;
            #1;
            chk("abort_state", 32'(state_o), 32'd0);
            chk("abort_outs", 32'(obs), 32'(rst_out()));
            @(negedge clk);
            chk("abort_hold_state", 32'(state_o), 32'd0);
            chk("abort_hold_outs", 32'(obs), 32'(rst_out()));
            rst = 1'b1;
            return;
         end
         chk($sformatf("state op=%h c%0d", op, i), 32'(state_o), 32'(q[i].st));
         chk($sformatf("outs op=%h c%0d", op, i), 32'(obs),
             32'(exp_out(q[i].st, q[i].rdy, q[i].to, op, fn, z)));
         @(negedge clk);
      end
   endtask

   initial begin
      logic [5:0] ops [6] = '{RT, LW, SW, BEQ, ADDI, J};
      logic [5:0] fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
      logic [5:0] op, fn;
      int wf, wm;
      mem_ready = 1'b1;
      #2;
      chk("reset_state", 32'(state_o), 32'd0);
      chk("reset_outs", 32'(obs), 32'(rst_out()));
      repeat (2) @(negedge clk);
      chk("reset_hold", 32'(obs), 32'(rst_out()));
      rst = 1'b1;

      run_instr(LW, 6'h20, 0, 0, 0, -1);
      run_instr(RT, 6'h22, 0, 0, 0, -1);
      run_instr(BEQ, 6'h00, 1, 0, 0, -1);
      run_instr(BEQ, 6'h00, 0, 0, 0, -1);
      run_instr(SW, 6'h00, 0, 0, 3, -1);
      run_instr(ADDI, 6'h00, 0, 0, 0, -1);
      run_instr(J, 6'h00, 0, 0, 0, -1);
      run_instr(LW, 6'h00, 0, TO + 1, 0, -1);   // fetch timeout
      run_instr(J, 6'h00, 0, TO, 0, -1);        // ready exactly at the limit
      run_instr(6'h3f, 6'h00, 0, 0, 0, -1);     // illegal opcode
      run_instr(RT, 6'h3f, 0, 0, 0, -1);        // illegal funct
      run_instr(SW, 6'h00, 0, 0, TO + 1, -1);   // write timeout
      run_instr(LW, 6'h00, 0, 0, TO + 1, -1);   // read timeout
      run_instr(LW, 6'h00, 0, 0, TO, -1);
      run_instr(LW, 6'h00, 0, 0, 5, 3);         // reset during MEMRD
      run_instr(LW, 6'h00, 0, TO, TO, -1);

      for (int n = 0; n < 300; n++) begin
         op = ($urandom % 8 == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
         fn = ($urandom % 6 == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
         wf = ($urandom % 4 == 0) ? $urandom_range(0, TO + 2) : 0;
         wm = ($urandom % 3 == 0) ? $urandom_range(0, TO + 2) : 0;
         run_instr(op, fn, 1'($urandom), wf, wm, ($urandom % 40 == 0) ? $urandom_range(0, 3) : -1);
      end
      mem_ready = 1'b0;
      #1;
      chk("final_state", 32'(state_o), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: maximum cycles spent waiting on mem_ready in one memory state (range 1..255).
REQ-002 SHALL have port clk, input, 1, single system clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port Opcode, input, 6, instruction bits [31:26] from the instruction register.
REQ-005 SHALL have port Funct, input, 6, instruction bits [5:0] from the instruction register.
REQ-006 SHALL have port Zero, input, 1, ALU zero flag.
REQ-007 SHALL have port mem_ready, input, 1, memory completes the current access in this cycle.
REQ-008 SHALL have outputs IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn, each 1 bit, with the standard multicycle MIPS datapath meaning.
REQ-009 SHALL have outputs ALUSrcB (2 bits: 00 reg B, 01 const 4, 10 sign-extended immediate, 11 shifted immediate) and PCSrc (2 bits: 00 ALU result, 01 ALUOut, 10 jump target).
REQ-010 SHALL have output ALUControl, 3 bits: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-011 SHALL have outputs state_o (4 bits, current state code), illegal (1-bit pulse) and bus_error (1-bit pulse).

Function
REQ-012 SHALL implement a Moore FSM with these states and codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11.
REQ-013 SHALL recognise these Opcodes: 000000 R-type, 100011 lw, 101011 sw, 000100 beq, 001000 addi, 000010 j.
REQ-014 SHALL drive in FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=010, PCSrc=00; IRWrite and PCEn SHALL equal mem_ready; the FSM SHALL advance to DECODE only in a cycle with mem_ready=1.
REQ-015 SHALL drive in DECODE: ALUSrcA=0, ALUSrcB=11, ALUControl=010, and branch by Opcode: lw/sw to MEMADR, R-type to EXEC, beq to BRANCH, addi to ADDIEX, j to JUMP, any other opcode to FETCH with illegal=1 for that cycle.
REQ-016 SHALL drive in MEMADR: ALUSrcA=1, ALUSrcB=10, ALUControl=010; next state MEMRD for lw, MEMWR for sw.
REQ-017 SHALL drive in MEMRD: MemRead=1, IorD=1; hold until mem_ready=1, then go to MEMWB.
REQ-018 SHALL drive in MEMWB: RegWrite=1, RegDst=0, MemtoReg=1; next state FETCH.
REQ-019 SHALL drive in MEMWR: MemWrite=1, IorD=1; hold until mem_ready=1, then go to FETCH.
REQ-020 SHALL drive in EXEC: ALUSrcA=1, ALUSrcB=00, ALUControl from Funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt); next state ALUWB; any other Funct SHALL instead go to FETCH with illegal=1 and no register write.
REQ-021 SHALL drive in ALUWB: RegWrite=1, RegDst=1, MemtoReg=0; next state FETCH.
REQ-022 SHALL drive in BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=110, PCSrc=01, PCEn=Zero; next state FETCH.
REQ-023 SHALL drive in ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUControl=010, then go to ADDIWB; in ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0, then go to FETCH.
REQ-024 SHALL drive in JUMP: PCSrc=10, PCEn=1; next state FETCH.
REQ-025 SHALL hold every signal not listed for a state at 0.
REQ-026 SHALL keep an 8-bit wait counter that clears on each entry to FETCH, MEMRD or MEMWR and increments for each cycle spent in that state with mem_ready=0.
REQ-027 SHALL, when the wait counter reaches TIMEOUT with mem_ready still 0, go to FETCH next cycle, pulse bus_error for 1 cycle, and suppress IRWrite, PCEn, RegWrite and MemWrite in that cycle.
REQ-028 SHALL give mem_ready=1 priority over a timeout occurring in the same cycle.
REQ-029 SHALL use the following cycle counts with zero-wait memory: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.

Reset
REQ-030 SHALL, while rst=0, force state to FETCH and the wait counter to 0, and hold MemRead, MemWrite, IRWrite, PCEn, RegWrite, illegal and bus_error at 0; all other outputs SHALL take their FETCH values.
REQ-031 SHALL, on rst asserted mid-instruction, abort the instruction immediately with no further write strobes, and SHALL begin a fresh fetch on the first rising edge after rst returns to 1.

Verification
REQ-032 SHALL be covered: reset, then mem_ready=1 constant, Opcode=100011 -> state_o 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-033 SHALL be covered: R-type with Funct=100010 -> ALUControl=110 in EXEC, RegWrite=1 with RegDst=1 in ALUWB, total 4 cycles.
REQ-034 SHALL be covered: beq with Zero=1 -> PCEn=1 and PCSrc=01 in BRANCH; repeat with Zero=0 -> PCEn=0.
REQ-035 SHALL be covered: sw with mem_ready low for 3 cycles in MEMWR -> MemWrite held for 4 cycles, state 5 then 0, no bus_error.
REQ-036 SHALL be covered: TIMEOUT=4, mem_ready=0 in FETCH -> bus_error pulse after 4 wait cycles, IRWrite=0 throughout, state returns to 0 with the counter cleared.
REQ-037 SHALL be covered: Opcode=111111 -> illegal=1 in DECODE, next state 0; rst dropped during MEMRD -> state_o=0 and all strobes 0 asynchronously.
